// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC and the fetch entry payload.
package cpu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   typedef struct packed {
      logic [DATA_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush empties it and overrides push/pop.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  entry_t                   wdata,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, one-cycle imem request port and a credit-managed prefetch FIFO.
module fetch_queue #(
   parameter int unsigned          DATA_W   = cpu_pkg::DATA_W,
   parameter int unsigned          ADDR_W   = cpu_pkg::ADDR_W,
   parameter int unsigned          DEPTH    = 4,
   parameter int unsigned          PC_STEP  = 1,
   parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic [DATA_W-1:0]        imem_rdata,
   output logic                     inst_valid,
   output logic [DATA_W-1:0]        inst_data,
   output logic [ADDR_W-1:0]        inst_pc,
   input  logic                     inst_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [DATA_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] rsp_pc;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [CW:0]       credit;
   logic              pop;
   logic              push;
   entry_t            wdata;
   entry_t            head;

   assign inst_valid = (count != '0);
   assign pop        = inst_valid & inst_ready;
   assign push       = inflight & ~redirect_valid;

   // Credit counts buffered plus in-flight words, net of the head leaving this cycle.
   assign credit   = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
   assign imem_req = rst & ~redirect_valid & (credit < (CW+1)'(DEPTH));

   assign imem_addr = pc;
   assign wdata     = '{inst: imem_rdata, pc: rsp_pc};
   assign inst_data = head.inst;
   assign inst_pc   = head.pc;
   assign occupancy = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         rsp_pc   <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         rsp_pc   <= pc;
         if (redirect_valid)
            pc <= redirect_pc;
         else if (imem_req)
            pc <= pc + ADDR_W'(PC_STEP);
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wdata),
      .head  (head),
      .count (count)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based behavioural model.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk            = 1'b0;
   logic        rst            = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata     = '0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready     = 1'b0;
   logic [2:0]  occupancy;

   int total = 0;
   int bad   = 0;

   // Model: delivered-but-unconsumed instructions as {data, pc}, plus the fetch front state.
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_rsp;
   bit          m_infl;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .occupancy      (occupancy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 32'h0;
      m_rsp  = 32'h0;
      m_infl = 1'b0;
   endtask

   // One clock cycle: drive, compare against the model, advance the model, answer imem.
   task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
      bit          pop;
      bit          req;
      bit          req_dut;
      logic [31:0] addr;
      @(negedge clk);
      redirect_valid = rv;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      #1;
      check("valid", 64'(inst_valid), 64'(mq.size() != 0));
      check("occ", 64'(occupancy), 64'(mq.size()));
      if (mq.size() != 0) begin
         check("head_pc", 64'(inst_pc), 64'(mq[0][31:0]));
         check("head_data", 64'(inst_data), 64'(mq[0][63:32]));
      end
      pop = (mq.size() != 0) && rdy;
      req = !rv && (int'(mq.size()) + int'(m_infl) - int'(pop) < int'(DEPTH));
      check("req", 64'(imem_req), 64'(req));
      check("addr", 64'(imem_addr), 64'(m_pc));
      req_dut = imem_req;
      addr    = imem_addr;
      if (rv) begin
         mq.delete();
         m_pc   = rpc;
         m_infl = 1'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_infl) mq.push_back({m_rsp + 32'h100, m_rsp});
         m_rsp  = m_pc;
         m_infl = req;
         if (req) m_pc = m_pc + 32'd1;
      end
      @(posedge clk);
      #1;
      imem_rdata = req_dut ? addr + 32'h100 : $urandom();
   endtask

   initial begin
      int n;
      model_reset();
      #3 rst = 1'b0;
      #9;
      check("rst_valid", 64'(inst_valid), 64'(0));
      check("rst_occ", 64'(occupancy), 64'(0));
      check("rst_req", 64'(imem_req), 64'(0));
      check("rst_addr", 64'(imem_addr), 64'(0));
      @(posedge clk);
      #2 rst = 1'b1;

      // Free-running decode.
      repeat (12) cycle(1'b0, 32'h0, 1'b1);
      // Decode stall then release.
      repeat (10) cycle(1'b0, 32'h0, 1'b0);
      repeat (10) cycle(1'b0, 32'h0, 1'b1);

      // Redirect with three buffered entries and one word in flight.
      n = 0;
      while (!(mq.size() == 3 && m_infl) && n < 20) begin
         cycle(1'b0, 32'h0, 1'b0);
         n++;
      end
      check("fill3_occ", 64'(occupancy), 64'(3));
      cycle(1'b1, 32'h40, 1'b0);
      repeat (6) cycle(1'b0, 32'h0, 1'b1);

      // Back-to-back redirects: only the second target survives.
      cycle(1'b1, 32'h40, 1'b1);
      cycle(1'b1, 32'h80, 1'b1);
      repeat (6) cycle(1'b0, 32'h0, 1'b1);

      // PC wrap across the top of the address space.
      cycle(1'b1, 32'hFFFF_FFFE, 1'b1);
      repeat (6) cycle(1'b0, 32'h0, 1'b1);

      // Random redirects and decode back-pressure.
      repeat (400) cycle($urandom_range(0, 7) == 0, $urandom(), $urandom_range(0, 3) != 0);

      // Async reset with two entries buffered.
      cycle(1'b1, 32'h200, 1'b0);
      n = 0;
      while (mq.size() != 2 && n < 20) begin
         cycle(1'b0, 32'h0, 1'b0);
         n++;
      end
      check("fill2_occ", 64'(occupancy), 64'(2));
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 64'(inst_valid), 64'(0));
      check("arst_occ", 64'(occupancy), 64'(0));
      check("arst_req", 64'(imem_req), 64'(0));
      check("arst_addr", 64'(imem_addr), 64'(0));
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      repeat (8) cycle(1'b0, 32'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
